weapon_controller: RTL and testbench
====================================

Name: weapon_controller

Overview:
- Initiator side of the fire interface: turns player button inputs into the `fire` / `fire_angle` / `fire_mode` signals that the enemy controller consumes.
- Owns aim angle, shooting mode, ammo magazine, per-mode cooldown and reload timing.
- Sits between the debounced button inputs and the enemy controller. Its timing is driven by a one-cycle `tick` strobe from the game timebase.

Parameters:
- MAG_SIZE, 8: magazine capacity in ammo units (1..15).
- CD_SPRAY, 4: cooldown after a mode-00 shot, in ticks (>=1).
- CD_NARROW, 8: cooldown after a mode-01 shot, in ticks (>=1).
- RELOAD_TICKS, 16: reload duration, in ticks (>=1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous reset, active-low
- tick  in  1  one-cycle game-timebase strobe
- btn_fire  in  1  debounced fire button, level
- btn_left  in  1  aim rotate down, level
- btn_right  in  1  aim rotate up, level
- btn_mode  in  1  debounced mode button, level
- fire  out  1  one-cycle shot pulse to the enemy controller
- fire_angle  out  4  aim angle, 0..15
- fire_mode  out  2  00 = spray, 01 = narrow; 10 and 11 are never driven
- ammo  out  4  remaining ammo
- busy  out  1  high in COOLDOWN or RELOAD

Behaviour:
- Reset (async, reset_n = 0):
  - Outputs: fire = 0, fire_angle = 0, fire_mode = 00, ammo = MAG_SIZE, busy = 0.
  - Internal: state = IDLE, counter = 0, edge registers = 0.
- Edge detect: btn_fire and btn_mode are rising-edge detected against a registered previous value. A button held through reset does not generate an edge on release of reset.
- Aim, evaluated only on cycles with tick = 1:
  - btn_right alone: angle + 1, 15 wraps to 0.
  - btn_left alone: angle - 1, 0 wraps to 15.
  - Both pressed or neither pressed: no change.
  - Aim updates in any state except the cycle fire = 1, so fire_angle is stable while fire is high.
- Mode: a btn_mode rising edge toggles fire_mode 00 <-> 01, in IDLE only; edges in any other state are discarded.
- Shot cost: spray = 1, narrow = 2.
- FSM states: IDLE, FIRE, COOLDOWN, RELOAD.
  - IDLE, btn_fire edge with ammo >= cost: go to FIRE.
  - IDLE, btn_fire edge with ammo < cost: go to RELOAD, no shot.
  - IDLE, simultaneous fire and mode edges: the mode toggle wins and the fire edge is dropped.
  - FIRE (exactly one cycle):
    - fire = 1.
    - ammo -= cost.
    - Counter loaded with CD_SPRAY or CD_NARROW according to the current mode.
    - Next state COOLDOWN.
    - Latency: edge at cycle N gives fire = 1 at cycle N+1 (registered).
  - COOLDOWN:
    - Counter decrements on tick.
    - On a tick with counter == 1: if ammo == 0, go to RELOAD (counter = RELOAD_TICKS), else go to IDLE.
    - The cooldown therefore spans exactly N ticks.
  - RELOAD:
    - Entered from IDLE with counter = RELOAD_TICKS.
    - Counter decrements on tick.
    - On a tick with counter == 1: ammo = MAG_SIZE, go to IDLE.
- No buffering: fire edges arriving in FIRE, COOLDOWN or RELOAD are discarded.
- Width rules: ammo arithmetic is 4-bit and never underflows, because cost is checked before FIRE. The counter is 5 bits wide.
- busy = 1 iff state is COOLDOWN or RELOAD (registered with the state).
- Reset mid-operation: every register returns immediately to its reset value. Any pending cooldown or reload is abandoned and ammo is refilled to MAG_SIZE.
- tick held high continuously is legal: one tick counted per cycle.

Decomposition:
- Shared package `game_pkg`:
  - Fire-mode encodings: FM_SPRAY = 2'b00, FM_NARROW = 2'b01.
  - Shot-cost constants.
  - Angle width = 4.
  - FSM state enum.
  - The package is also imported by the enemy controller so both ends agree on the encodings.
- One natural sub-module: `edge_detect`, a 1-bit rising-edge detector instantiated for btn_fire and btn_mode.

Test Plan:
- Reset, then one btn_fire edge in mode 00 -> fire high for exactly 1 cycle, one cycle after the edge; ammo 8 -> 7; busy for exactly 4 ticks, then IDLE.
- btn_right held for 17 ticks from angle 0 -> angle 1 (wrap at 15->0). btn_left and btn_right both held -> angle unchanged. Angle does not change during the fire cycle.
- Toggle to mode 01 and fire 4 times with cooldowns elapsing -> 4 fire pulses, ammo 8 -> 0. After the 8-tick cooldown, RELOAD lasts 16 ticks, then ammo = 8 and busy = 0.
- Mode 01 with ammo = 1, btn_fire edge -> no fire pulse, RELOAD entered, ammo = 8 after 16 ticks.
- btn_fire edges during COOLDOWN and during RELOAD, and btn_mode edge during COOLDOWN -> no fire pulse, fire_mode unchanged.
- reset_n asserted mid-RELOAD with btn_fire held high -> outputs at reset values immediately; after release, no fire until a new btn_fire rising edge.

Source files
------------

// File: rtl/game_pkg.sv
// Shared fire-interface encodings, shot costs and weapon FSM states.
// Imported by both the weapon controller and the enemy controller.
package game_pkg;

  localparam int ANGLE_W = 4;

  localparam logic [1:0] FM_SPRAY  = 2'b00;
  localparam logic [1:0] FM_NARROW = 2'b01;

  localparam logic [3:0] COST_SPRAY  = 4'd1;
  localparam logic [3:0] COST_NARROW = 4'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIRE,
    ST_COOLDOWN,
    ST_RELOAD
  } wc_state_e;

  function automatic logic [3:0] shot_cost(input logic [1:0] mode);
    return (mode == FM_NARROW) ? COST_NARROW : COST_SPRAY;
  endfunction

endpackage

// File: rtl/weapon_controller_if.sv
// Button inputs and fire-interface outputs of the weapon controller.
// The master modport is the weapon controller side.
interface weapon_controller_if;
  import game_pkg::*;

  logic               tick;
  logic               btn_fire;
  logic               btn_left;
  logic               btn_right;
  logic               btn_mode;
  logic               fire;
  logic [ANGLE_W-1:0] fire_angle;
  logic [1:0]         fire_mode;
  logic [3:0]         ammo;
  logic               busy;

  modport master (
    input  tick, btn_fire, btn_left, btn_right, btn_mode,
    output fire, fire_angle, fire_mode, ammo, busy
  );

  modport slave (
    output tick, btn_fire, btn_left, btn_right, btn_mode,
    input  fire, fire_angle, fire_mode, ammo, busy
  );

endinterface

// File: rtl/weapon_controller_edge_detect.sv
// 1-bit rising-edge detector. Stays disarmed for one cycle after reset so a
// button held through reset does not produce an edge.
module edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise
);

  logic prev_q;
  logic arm_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= 1'b0;
      arm_q  <= 1'b0;
    end else begin
      prev_q <= d;
      arm_q  <= 1'b1;
    end
  end

  assign rise = d & ~prev_q & arm_q;

endmodule

// File: rtl/weapon_controller.sv
// Weapon controller: aim, mode, magazine, cooldown and reload timing that
// drive the fire / fire_angle / fire_mode interface to the enemy controller.
module weapon_controller
  import game_pkg::*;
#(
  parameter int MAG_SIZE     = 8,
  parameter int CD_SPRAY     = 4,
  parameter int CD_NARROW    = 8,
  parameter int RELOAD_TICKS = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  weapon_controller_if.master bus
);

  localparam logic [3:0] MAG_FULL   = 4'(MAG_SIZE);
  localparam logic [4:0] CNT_SPRAY  = 5'(CD_SPRAY);
  localparam logic [4:0] CNT_NARROW = 5'(CD_NARROW);
  localparam logic [4:0] CNT_RELOAD = 5'(RELOAD_TICKS);

  wc_state_e          state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [3:0]         ammo_q, ammo_d;
  logic [ANGLE_W-1:0] angle_q, angle_d;
  logic [1:0]         mode_q, mode_d;
  logic               fire_rise;
  logic               mode_rise;
  logic [3:0]         cost;

  edge_detect u_fire_edge (.clk(clk), .reset_n(reset_n), .d(bus.btn_fire), .rise(fire_rise));
  edge_detect u_mode_edge (.clk(clk), .reset_n(reset_n), .d(bus.btn_mode), .rise(mode_rise));

  assign cost = shot_cost(mode_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ammo_q  <= MAG_FULL;
      angle_q <= '0;
      mode_q  <= FM_SPRAY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ammo_q  <= ammo_d;
      angle_q <= angle_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ammo_d  = ammo_q;
    angle_d = angle_q;
    mode_d  = mode_q;

    // Aim is frozen during the FIRE cycle so the angle is stable with the pulse.
    if (bus.tick && (state_q != ST_FIRE)) begin
      if (bus.btn_right && !bus.btn_left)      angle_d = angle_q + 1'b1;
      else if (bus.btn_left && !bus.btn_right) angle_d = angle_q - 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (mode_rise) begin
          mode_d = (mode_q == FM_SPRAY) ? FM_NARROW : FM_SPRAY;
        end else if (fire_rise) begin
          if (ammo_q >= cost) begin
            state_d = ST_FIRE;
          end else begin
            state_d = ST_RELOAD;
            cnt_d   = CNT_RELOAD;
          end
        end
      end
      ST_FIRE: begin
        ammo_d  = ammo_q - cost;
        cnt_d   = (mode_q == FM_NARROW) ? CNT_NARROW : CNT_SPRAY;
        state_d = ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        if (bus.tick) begin
          if (cnt_q == 5'd1) begin
            if (ammo_q == 4'd0) begin
              state_d = ST_RELOAD;
              cnt_d   = CNT_RELOAD;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
      end
      ST_RELOAD: begin
        if (bus.tick) begin
          if (cnt_q == 5'd1) begin
            ammo_d  = MAG_FULL;
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.fire       = (state_q == ST_FIRE);
  assign bus.busy       = (state_q == ST_COOLDOWN) || (state_q == ST_RELOAD);
  assign bus.fire_angle = angle_q;
  assign bus.fire_mode  = mode_q;
  assign bus.ammo       = ammo_q;

endmodule

// File: tb/tb_weapon_controller.sv
// Directed bench for weapon_controller with a shot scoreboard: each fire edge
// pushes the expected angle/mode, each observed fire pulse pops and compares.
module tb_weapon_controller;
  import game_pkg::*;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  weapon_controller_if bus ();

  weapon_controller #(
    .MAG_SIZE(8), .CD_SPRAY(4), .CD_NARROW(8), .RELOAD_TICKS(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  typedef struct {
    logic [3:0] angle;
    logic [1:0] mode;
  } shot_t;

  shot_t      exp_q[$];
  int         errors    = 0;
  int         checks    = 0;
  int         fire_cnt  = 0;
  int         shots_exp = 0;
  logic [3:0] m_angle   = 4'd0;
  logic [3:0] m_ammo    = 4'd8;
  logic [1:0] m_mode    = FM_SPRAY;

  always @(negedge clk) if (bus.fire === 1'b1) fire_cnt++;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b1;
      step(1);
      bus.tick = 1'b0;
    end
  endtask

  task automatic pulse_mode();
    bus.btn_mode = 1'b1;
    step(1);
    bus.btn_mode = 1'b0;
    step(1);
  endtask

  // One shot from IDLE followed by its full cooldown; poke injects fire and
  // mode edges mid-cooldown that must be discarded.
  task automatic fire_shot(input string tag, input int cd, input bit poke);
    shot_t s;
    shot_t got;
    bit    found = 1'b0;
    int    lat   = 0;
    s.angle = m_angle;
    s.mode  = m_mode;
    exp_q.push_back(s);
    shots_exp++;
    bus.btn_fire = 1'b1;
    step(1);
    for (int k = 0; k < 4 && !found; k++) begin
      if (bus.fire === 1'b1) begin
        found = 1'b1;
        lat   = k;
        got   = exp_q.pop_front();
        chk({tag, "_angle"}, 32'(bus.fire_angle), 32'(got.angle));
        chk({tag, "_mode"}, 32'(bus.fire_mode), 32'(got.mode));
        chk({tag, "_ammo_pre"}, 32'(bus.ammo), 32'(m_ammo));
      end else begin
        step(1);
      end
    end
    chk({tag, "_seen"}, 32'(found), 32'd1);
    chk({tag, "_latency"}, lat, 0);
    if (!found) exp_q.delete();
    step(1);
    bus.btn_fire = 1'b0;
    m_ammo -= shot_cost(m_mode);
    chk({tag, "_one_cycle"}, 32'(bus.fire), 32'd0);
    chk({tag, "_ammo_post"}, 32'(bus.ammo), 32'(m_ammo));
    chk({tag, "_busy_cd"}, 32'(bus.busy), 32'd1);
    if (poke) begin
      ticks(1);
      bus.btn_fire = 1'b1;
      step(1);
      bus.btn_fire = 1'b0;
      pulse_mode();
      chk({tag, "_cd_no_fire"}, fire_cnt, shots_exp);
      chk({tag, "_cd_mode_kept"}, 32'(bus.fire_mode), 32'(m_mode));
      ticks(cd - 2);
    end else begin
      ticks(cd - 1);
    end
    chk({tag, "_busy_last"}, 32'(bus.busy), 32'd1);
    ticks(1);
    chk({tag, "_busy_end"}, 32'(bus.busy), 32'(m_ammo == 4'd0));
  endtask

  initial begin
    shot_t got;
    bus.tick      = 1'b0;
    bus.btn_fire  = 1'b0;
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b0;
    bus.btn_mode  = 1'b0;
    step(3);
    chk("rst_fire", 32'(bus.fire), 32'd0);
    chk("rst_angle", 32'(bus.fire_angle), 32'd0);
    chk("rst_mode", 32'(bus.fire_mode), 32'(FM_SPRAY));
    chk("rst_ammo", 32'(bus.ammo), 32'd8);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    reset_n = 1'b1;
    step(2);

    // single spray shot, 4-tick cooldown
    fire_shot("spray1", 4, 1'b0);
    chk("spray1_count", fire_cnt, shots_exp);

    // aim: wrap up, both held, wrap down
    bus.btn_right = 1'b1;
    ticks(17);
    chk("aim_wrap_up", 32'(bus.fire_angle), 32'd1);
    bus.btn_left = 1'b1;
    ticks(3);
    chk("aim_both", 32'(bus.fire_angle), 32'd1);
    bus.btn_right = 1'b0;
    ticks(2);
    chk("aim_wrap_down", 32'(bus.fire_angle), 32'd15);
    bus.btn_left = 1'b0;

    // aim updates on the edge cycle (15->0) but freezes during FIRE
    got.angle = 4'd0;
    got.mode  = m_mode;
    exp_q.push_back(got);
    shots_exp++;
    bus.btn_fire  = 1'b1;
    bus.btn_right = 1'b1;
    bus.tick      = 1'b1;
    step(1);
    chk("frz_fire", 32'(bus.fire), 32'd1);
    got = exp_q.pop_front();
    chk("frz_angle", 32'(bus.fire_angle), 32'(got.angle));
    step(1);
    chk("frz_hold", 32'(bus.fire_angle), 32'd0);
    bus.tick      = 1'b0;
    bus.btn_right = 1'b0;
    bus.btn_fire  = 1'b0;
    m_angle = 4'd0;
    m_ammo  = 4'd6;
    chk("frz_ammo", 32'(bus.ammo), 32'd6);
    ticks(4);
    chk("frz_idle", 32'(bus.busy), 32'd0);

    // short reset in IDLE refills the magazine
    reset_n = 1'b0;
    step(1);
    chk("refill_ammo", 32'(bus.ammo), 32'd8);
    reset_n = 1'b1;
    step(2);
    m_ammo = 4'd8;

    // narrow: four shots empty the magazine, then a 16-tick reload
    pulse_mode();
    m_mode = FM_NARROW;
    chk("mode_narrow", 32'(bus.fire_mode), 32'(FM_NARROW));
    for (int i = 0; i < 4; i++) fire_shot("narrow", 8, 1'b0);
    chk("narrow_count", fire_cnt, shots_exp);
    chk("reload_ammo0", 32'(bus.ammo), 32'd0);
    ticks(15);
    chk("reload_busy15", 32'(bus.busy), 32'd1);
    ticks(1);
    chk("reload_done_busy", 32'(bus.busy), 32'd0);
    chk("reload_done_ammo", 32'(bus.ammo), 32'd8);
    m_ammo = 4'd8;

    // bring ammo to 1, discarding edges mid-cooldown on the way
    pulse_mode();
    m_mode = FM_SPRAY;
    fire_shot("sp7", 4, 1'b0);
    pulse_mode();
    m_mode = FM_NARROW;
    fire_shot("nr5", 8, 1'b1);
    fire_shot("nr3", 8, 1'b0);
    fire_shot("nr1", 8, 1'b0);
    bus.btn_fire = 1'b1;
    step(1);
    bus.btn_fire = 1'b0;
    chk("low_no_fire", 32'(bus.fire), 32'd0);
    chk("low_reload", 32'(bus.busy), 32'd1);
    chk("low_ammo", 32'(bus.ammo), 32'd1);
    ticks(4);
    bus.btn_fire = 1'b1;
    step(1);
    bus.btn_fire = 1'b0;
    pulse_mode();
    chk("rl_no_fire", fire_cnt, shots_exp);
    chk("rl_mode_kept", 32'(bus.fire_mode), 32'(FM_NARROW));
    ticks(11);
    chk("low_busy15", 32'(bus.busy), 32'd1);
    ticks(1);
    chk("low_done_ammo", 32'(bus.ammo), 32'd8);
    chk("low_done_busy", 32'(bus.busy), 32'd0);
    m_ammo = 4'd8;

    // reset mid-reload with btn_fire held across release
    for (int i = 0; i < 4; i++) fire_shot("nr_again", 8, 1'b0);
    ticks(5);
    bus.btn_fire = 1'b1;
    step(1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_fire", 32'(bus.fire), 32'd0);
    chk("mid_rst_angle", 32'(bus.fire_angle), 32'd0);
    chk("mid_rst_mode", 32'(bus.fire_mode), 32'(FM_SPRAY));
    chk("mid_rst_ammo", 32'(bus.ammo), 32'd8);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    step(2);
    reset_n = 1'b1;
    step(4);
    chk("held_no_fire", fire_cnt, shots_exp);
    chk("held_idle", 32'(bus.busy), 32'd0);
    bus.btn_fire = 1'b0;
    step(1);
    m_ammo  = 4'd8;
    m_mode  = FM_SPRAY;
    m_angle = 4'd0;
    fire_shot("post_rst", 4, 1'b0);

    chk("queue_empty", exp_q.size(), 0);
    chk("total_shots", fire_cnt, shots_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
